instruction_encoder: RTL and testbench

Packs opcode, register and immediate fields into 16-bit instructions, the inverse of the core's immediate decode. It range-checks each immediate against its format and buffers packed words in a small FIFO. It then streams them to the instruction-memory loader with a write address that increments on each transfer. The block sits between the boot/program loader and instruction memory.

---
 rtl/instruction_encoder.sv | 162 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Packs opcode/register/immediate fields into 16-bit instructions and streams them to imem with an incrementing write address.
// Latency: a bundle accepted at edge N is visible on instr/instr_valid after edge N; imm_err follows the accepting edge.
// Backpressure: in_ready drops when the FIFO is full or once the last bundle is taken; instr/imem_addr hold while stalled.
// Optional feature macro: IMM_SATURATE_EN (clamp out-of-range immediates and write them instead of dropping).
module instruction_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [1:0]        imm_src,
  input  logic [2:0]        rd,
  input  logic [2:0]        rs,
  input  logic [2:0]        rt,
  input  logic [7:0]        imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imm_err,
  output logic [7:0]        err_count,
  output logic              done
);

  localparam int PW = $clog2(DEPTH);

`ifdef IMM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_mem [DEPTH];
  logic [PW:0]       r_wptr;
  logic [PW:0]       r_rptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_imm_err;
  logic [7:0]        r_err_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_range_err;
  logic [15:0]       w_word;
  logic [5:0]        w_imm6;
  logic [2:0]        w_imm3;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_empty     = (r_wptr == r_rptr);

  assign in_ready    = (r_state == S_LOAD) && !w_full;
  assign w_accept    = in_valid && in_ready;
  // Range-failing bundles are only written when saturation is enabled.
  assign w_push      = w_accept && (!w_range_err || SAT_EN);
  assign instr_valid = !w_empty;
  assign w_pop       = instr_valid && instr_ready;

  assign instr       = w_empty ? 16'h0000 : r_mem[r_rptr[PW-1:0]];
  assign imem_addr   = r_addr;
  assign imm_err     = r_imm_err;
  assign err_count   = r_err_cnt;
  assign done        = (r_state == S_DONE);

  // Field packing and immediate range check per format.
  always_comb begin
    w_range_err = 1'b0;
    w_word      = 16'h0000;
    w_imm6      = imm[5:0];
    w_imm3      = imm[2:0];
    case (imm_src)
      2'b00: begin
        w_word = {opcode, imm, rd, 1'b0};
      end
      2'b01: begin
        // Signed -32..31: bits [7:5] must be a pure sign extension.
        w_range_err = !((imm[7:5] == 3'b000) || (imm[7:5] == 3'b111));
        if (SAT_EN && w_range_err) begin
          w_imm6 = imm[7] ? 6'b100000 : 6'b011111;
        end
        w_word = {opcode, rd, rs, w_imm6};
      end
      2'b10: begin
        // Shift amount 0..7: any upper bit set is out of range.
        w_range_err = (imm[7:3] != 5'd0);
        if (SAT_EN && w_range_err) begin
          w_imm3 = imm[7] ? 3'd0 : 3'd7;
        end
        w_word = {opcode, rd, rs, w_imm3, 3'b000};
      end
      default: begin
        w_word = {opcode, rd, rs, rt, 3'b000};
      end
    endcase
  end

  // FIFO storage; contents need no reset because instr is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= w_word;
    end
  end

  // FIFO pointers, write address counter and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_addr    <= '0;
      r_imm_err <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PW+1)'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end
      r_imm_err <= w_accept && w_range_err;
      if (w_accept && w_range_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Load-phase state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: last bundle taken (even if dropped) ends loading; empty FIFO ends draining.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty)             w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LOAD;
    endcase
  end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [1:0]  imm_src = 2'b00;
  logic [2:0]  rd = 3'd0;
  logic [2:0]  rs = 3'd0;
  logic [2:0]  rt = 3'd0;
  logic [7:0]  imm = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  imem_addr;
  logic        imm_err;
  logic [7:0]  err_count;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  int exp_addr = 0;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .imm_src(imm_src), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .imem_addr(imem_addr), .imm_err(imm_err), .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one bundle for a single clock edge.
  task automatic push(input logic [3:0] op, input logic [1:0] src, input logic [2:0] d,
                      input logic [2:0] s, input logic [2:0] t, input logic [7:0] im,
                      input logic last);
    opcode = op; imm_src = src; rd = d; rs = s; rt = t; imm = im; in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Checks the FIFO head and its address, then pops it.
  task automatic pop_check(input string tag, input logic [15:0] exp);
    check({tag, "_vld"}, 16'(instr_valid), 16'h1);
    check({tag, "_instr"}, instr, exp);
    check({tag, "_addr"}, 16'(imem_addr), 16'(exp_addr[7:0]));
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    exp_addr++;
  endtask

  initial begin
    int waited;
    int n;
    logic [15:0] fill_words [4];
    fill_words[0] = 16'hA280; fill_words[1] = 16'hA288;
    fill_words[2] = 16'hA290; fill_words[3] = 16'hA298;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_instr_valid", 16'(instr_valid), 16'h0);
    check("rst_instr", instr, 16'h0000);
    check("rst_imem_addr", 16'(imem_addr), 16'h0);
    check("rst_imm_err", 16'(imm_err), 16'h0);
    check("rst_err_count", 16'(err_count), 16'h0);
    check("rst_done", 16'(done), 16'h0);

    // Format 00, one-cycle latency
    push(4'h3, 2'b00, 3'd2, 3'd0, 3'd0, 8'hA5, 1'b0);
    check("f00_imm_err", 16'(imm_err), 16'h0);
    pop_check("f00", 16'h3A54);
    check("f00_empty_after", 16'(instr_valid), 16'h0);

    // Format 01: legal -5, then out-of-range 40
    push(4'h5, 2'b01, 3'd1, 3'd2, 3'd0, 8'hFB, 1'b0);
    push(4'h5, 2'b01, 3'd1, 3'd2, 3'd0, 8'd40, 1'b0);
    check("f01_err_pulse", 16'(imm_err), 16'h1);
    check("f01_err_count", 16'(err_count), 16'h1);
    @(negedge clk);
    check("f01_err_pulse_end", 16'(imm_err), 16'h0);
    pop_check("f01_ok", 16'h52BB);
`ifdef IMM_SATURATE_EN
    pop_check("f01_sat", 16'h529F);
`endif
    check("f01_dropped", 16'(instr_valid), 16'h0);

    // Format 10: legal 5, then out-of-range 8
    push(4'h7, 2'b10, 3'd3, 3'd4, 3'd0, 8'd5, 1'b0);
    push(4'h7, 2'b10, 3'd3, 3'd4, 3'd0, 8'd8, 1'b0);
    check("f10_err_pulse", 16'(imm_err), 16'h1);
    check("f10_err_count", 16'(err_count), 16'h2);
    pop_check("f10_ok", 16'h7728);
`ifdef IMM_SATURATE_EN
    pop_check("f10_sat", 16'h7738);
`endif

    // Format 01 lower boundary -32 is legal
    push(4'h5, 2'b01, 3'd1, 3'd2, 3'd0, 8'hE0, 1'b0);
    check("f01_min_no_err", 16'(imm_err), 16'h0);
    check("f01_min_count", 16'(err_count), 16'h2);
    pop_check("f01_min", 16'h52A0);

    // Fill FIFO with consumer stalled (format 11, imm ignored)
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("fill_ready_before_4th", 16'(in_ready), 16'h1);
      push(4'hA, 2'b11, 3'd1, 3'd2, 3'(k), 8'hFF, 1'b0);
    end
    check("full_in_ready", 16'(in_ready), 16'h0);
    check("full_no_err", 16'(err_count), 16'h2);
    opcode = 4'hF; imm_src = 2'b11; rt = 3'd7; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("full_held_ready", 16'(in_ready), 16'h0);
    check("full_stable_instr", instr, 16'hA280);
    check("full_stable_addr", 16'(imem_addr), 16'(exp_addr[7:0]));
    for (int k = 0; k < 4; k++) pop_check("fill_drain", fill_words[k]);
    check("fill_no_5th", 16'(instr_valid), 16'h0);

    // Stream to wrap the write address
    n = 260 - exp_addr;
    opcode = 4'h1; imm_src = 2'b00; rd = 3'd0; imm = 8'h11;
    in_valid = 1'b1; instr_ready = 1'b1;
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (instr_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    instr_ready = 1'b0;
    check("wrap_drain_timeout", 16'(instr_valid), 16'h0);
    exp_addr = (exp_addr + n) % 256;
    check("wrap_addr", 16'(imem_addr), 16'(exp_addr[7:0]));

    // Mid-operation reset with 3 words queued
    for (int k = 0; k < 3; k++) push(4'h2, 2'b00, 3'd1, 3'd0, 3'd0, 8'(k), 1'b0);
    check("pre_rst_valid", 16'(instr_valid), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_addr = 0;
    check("mrst_instr_valid", 16'(instr_valid), 16'h0);
    check("mrst_imem_addr", 16'(imem_addr), 16'h0);
    check("mrst_err_count", 16'(err_count), 16'h0);
    check("mrst_in_ready", 16'(in_ready), 16'h1);

    // Last bundle: LOAD -> DRAIN -> DONE
    push(4'h3, 2'b00, 3'd2, 3'd0, 3'd0, 8'hA5, 1'b1);
    check("drain_in_ready", 16'(in_ready), 16'h0);
    check("drain_done", 16'(done), 16'h0);
    pop_check("drain_word", 16'h3A54);
    check("drain_empty_not_done", 16'(done), 16'h0);
    @(negedge clk);
    check("done_set", 16'(done), 16'h1);
    check("done_in_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_hold", 16'(done), 16'h1);
    check("done_no_accept", 16'(instr_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
